// File: rtl/load_store_unit_pkg.sv
// Shared RV32I memory-op encodings and LSU state/size types; also imported by
// the load extender and the decoder.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    function automatic logic lsu_illegal(input logic rd, input logic wr, input logic [2:0] f3);
        logic load_ok;
        load_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                  (f3 == F3_BU) || (f3 == F3_HU);
        return (rd & wr) | (rd & ~load_ok) | (wr & f3[2]);
    endfunction

    // funct3[1:0] = 11 only reaches here for stores; it is aligned like a word.
    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == SZ_HALF) & off[0]) | (f3[1] & (off != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering between the core and the 32-bit data bus: store
// replication with strobes, and load right-alignment with upper bits cleared.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  byte_off,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    assign shifted = mem_rdata >> {byte_off, 3'b000};

    always_comb begin
        wdata     = store_data;
        wstrb     = 4'b1111;
        load_data = shifted;
        case (size)
            SZ_BYTE: begin
                wdata     = {4{store_data[7:0]}};
                wstrb     = 4'b0001 << byte_off;
                load_data = {24'h000000, shifted[7:0]};
            end
            SZ_HALF: begin
                wdata     = {2{store_data[15:0]}};
                wstrb     = 4'b0011 << byte_off;
                load_data = {16'h0000, shifted[15:0]};
            end
            default: begin
                wdata     = store_data;
                wstrb     = 4'b1111;
                load_data = shifted;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: word-aligned req/ack bus master with byte
// strobes, load right-alignment, pipeline stall and error reporting.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no op in flight; classify and accept a presented op
// WAIT    | bus request outstanding, counting cycles toward timeout
// DONE    | one-cycle completion; lsu_done and flags valid
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_valid,
    input  logic        lsu_read,
    input  logic        lsu_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] read_data_mem,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic        misaligned,
    output logic        access_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e     state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]     op_size;
    logic [1:0]     op_off;
    logic           op_load;

    logic op_req;
    logic accept, reject_err, reject_mis, ack_done, timeout;

    logic [1:0]  align_size;
    logic [1:0]  align_off;
    logic [31:0] align_wdata;
    logic [3:0]  align_wstrb;
    logic [31:0] align_load;

    assign op_req = lsu_valid & (lsu_read | lsu_write);

    // Stores are steered from live inputs at acceptance; loads are aligned
    // from the latched op, since execute may change its outputs during WAIT.
    assign align_size = (state == ST_IDLE) ? funct3[1:0] : op_size;
    assign align_off  = (state == ST_IDLE) ? addr[1:0]   : op_off;

    lsu_lane_align u_lane_align (
        .size       (align_size),
        .byte_off   (align_off),
        .store_data (store_data),
        .mem_rdata  (mem_rdata),
        .wdata      (align_wdata),
        .wstrb      (align_wstrb),
        .load_data  (align_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject_err = 1'b0;
        reject_mis = 1'b0;
        ack_done   = 1'b0;
        timeout    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (op_req) begin
                    if (lsu_illegal(lsu_read, lsu_write, funct3)) begin
                        reject_err = 1'b1;
                        state_next = ST_DONE;
                    end else if (lsu_misaligned(funct3, addr[1:0])) begin
                        reject_mis = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        accept     = 1'b1;
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // An ack in the terminal-count cycle takes priority over timeout.
                if (mem_ack) begin
                    ack_done   = 1'b1;
                    state_next = ST_DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout    = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign lsu_done  = (state == ST_DONE);
    assign lsu_stall = op_req & (state != ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            op_size       <= 2'b00;
            op_off        <= 2'b00;
            op_load       <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 32'h0;
            mem_wdata     <= 32'h0;
            mem_wstrb     <= 4'h0;
            read_data_mem <= 32'h0;
            misaligned    <= 1'b0;
            access_err    <= 1'b0;
        end else begin
            if (accept) begin
                cnt       <= '0;
                op_size   <= funct3[1:0];
                op_off    <= addr[1:0];
                op_load   <= lsu_read;
                mem_req   <= 1'b1;
                mem_we    <= lsu_write;
                mem_addr  <= {addr[31:2], 2'b00};
                mem_wdata <= lsu_write ? align_wdata : 32'h0;
                mem_wstrb <= lsu_write ? align_wstrb : 4'h0;
            end
            if (state == ST_WAIT && !mem_ack) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (ack_done || timeout) begin
                mem_req   <= 1'b0;
                mem_we    <= 1'b0;
                mem_wstrb <= 4'h0;
            end
            if (ack_done && op_load) begin
                read_data_mem <= align_load;
            end
            if (timeout) begin
                access_err <= 1'b1;
                if (op_load) begin
                    read_data_mem <= 32'h0;
                end
            end
            if (reject_err) begin
                access_err <= 1'b1;
            end
            if (reject_mis) begin
                misaligned <= 1'b1;
            end
            if (state == ST_DONE) begin
                access_err <= 1'b0;
                misaligned <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: randomized ops against a byte-level
// reference model, with a latency-programmable memory responder.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int T = 16;

    logic        clk, rst_n;
    logic        lsu_valid, lsu_read, lsu_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] read_data_mem;
    logic        lsu_stall, lsu_done, misaligned, access_err;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_valid(lsu_valid), .lsu_read(lsu_read), .lsu_write(lsu_write),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .read_data_mem(read_data_mem), .lsu_stall(lsu_stall),
        .lsu_done(lsu_done), .misaligned(misaligned), .access_err(access_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          len;
    } bus_exp_t;

    typedef struct {
        logic        mis;
        logic        err;
        logic [31:0] rdm;
        int          done_cyc;
    } res_exp_t;

    bus_exp_t bq[$];
    res_exp_t rq[$];
    bus_exp_t cur_b;
    res_exp_t cur_r;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ack_lat = -1;
    logic [31:0] rdata_val = 32'h0;
    logic [31:0] model_rdm = 32'h0;
    bit mon_en = 1'b0;
    int req_cyc = 0;
    int req_len = 0;
    logic prev_req = 1'b0;

    logic [2:0] ld_ok [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] ld_bad [3] = '{3'b011, 3'b110, 3'b111};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory: acks after ack_lat extra cycles of mem_req; random stray acks otherwise.
    always @(negedge clk) begin
        if (mem_req) begin
            req_cyc++;
            mem_ack = (ack_lat >= 0) && (req_cyc == ack_lat + 1);
        end else begin
            req_cyc = 0;
            mem_ack = ($urandom_range(0, 7) == 0);
        end
        mem_rdata = (mem_ack && mem_req) ? rdata_val : $urandom;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_req && !prev_req) begin
                req_len = 1;
                if (bq.size() == 0) begin
                    chk("unexpected_req", 32'd1, 32'd0);
                    cur_b = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb, len: 0};
                end else begin
                    cur_b = bq.pop_front();
                end
            end else if (mem_req) begin
                req_len++;
            end
            if (mem_req) begin
                chk("bus_we", {31'b0, mem_we}, {31'b0, cur_b.we});
                chk("bus_addr", mem_addr, cur_b.addr);
                chk("bus_wdata", mem_wdata, cur_b.wdata);
                chk("bus_wstrb", {28'b0, mem_wstrb}, {28'b0, cur_b.wstrb});
            end
            if (!mem_req && prev_req) begin
                chk("req_len", req_len, cur_b.len);
                chk("we_wstrb_drop", {27'b0, mem_we, mem_wstrb}, 32'd0);
            end
        end
        prev_req = mem_req;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (lsu_done) begin
                if (rq.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    cur_r = rq.pop_front();
                    chk("done_cycle", cyc, cur_r.done_cyc);
                    chk("misaligned", {31'b0, misaligned}, {31'b0, cur_r.mis});
                    chk("access_err", {31'b0, access_err}, {31'b0, cur_r.err});
                    chk("read_data_mem", read_data_mem, cur_r.rdm);
                    chk("stall_at_done", {31'b0, lsu_stall}, 32'd0);
                end
            end else begin
                chk("flags_idle", {30'b0, misaligned, access_err}, 32'd0);
            end
        end
    end

    task automatic scramble();
        lsu_valid  = 1'($urandom_range(0, 1));
        lsu_read   = 1'($urandom_range(0, 1));
        lsu_write  = 1'($urandom_range(0, 1));
        funct3     = 3'($urandom_range(0, 7));
        addr       = $urandom;
        store_data = $urandom;
    endtask

    task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input int lat, input logic [31:0] rdat);
        int size, off, issue;
        logic ill, mis, acked, seen;
        logic [31:0] ld, wd;
        logic [3:0] ws;
        bus_exp_t b;
        res_exp_t r;
        off  = int'(a[1:0]);
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        ill  = (rd && wr) || (rd && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) || (wr && f3[2]);
        mis  = !ill && ((off % size) != 0);
        acked = (lat >= 0) && (lat < T);
        wd = 32'h0;
        ws = 4'h0;
        ld = 32'h0;
        for (int j = 0; j < 4; j++) begin
            wd[8*j +: 8] = d[8*(j % size) +: 8];
            ws[j] = (j >= off) && (j < off + size);
        end
        for (int i = 0; i < size; i++) begin
            if (off + i < 4) ld[8*i +: 8] = rdat[8*(off+i) +: 8];
        end

        @(posedge clk);
        #1;
        issue = cyc;
        ack_lat   = lat;
        rdata_val = rdat;
        lsu_valid = 1'b1;
        lsu_read  = rd;
        lsu_write = wr;
        funct3    = f3;
        addr      = a;
        store_data = d;

        if (ill || mis) begin
            r.done_cyc = issue + 1;
            r.err = ill;
            r.mis = mis;
        end else begin
            b.we    = wr;
            b.addr  = {a[31:2], 2'b00};
            b.wdata = wr ? wd : 32'h0;
            b.wstrb = wr ? ws : 4'h0;
            b.len   = acked ? lat + 1 : T;
            bq.push_back(b);
            r.done_cyc = issue + 2 + (acked ? lat : T - 1);
            r.err = !acked;
            r.mis = 1'b0;
            if (rd) model_rdm = acked ? ld : 32'h0;
        end
        r.rdm = model_rdm;
        rq.push_back(r);

        @(negedge clk);
        chk("stall_accept", {31'b0, lsu_stall}, 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            @(negedge clk);
            if (lsu_done) seen = 1'b1;
            else if (mem_req && $urandom_range(0, 1) == 1) scramble();
        end
        if (!seen) chk("op_completes", 32'd0, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic rd, wr;
        logic [2:0] f3;
        int lat, r;

        rst_n = 1'b0;
        lsu_valid = 1'b0; lsu_read = 1'b0; lsu_write = 1'b0;
        funct3 = 3'b0; addr = 32'h0; store_data = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_bus", {mem_req, mem_we, mem_wstrb}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdm", read_data_mem, 32'd0);
        chk("rst_status", {lsu_done, misaligned, access_err, lsu_stall}, 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        do_op(0, 1, F3_W, 32'h0000_0100, 32'hDEAD_BEEF, 2, 32'h0);
        do_op(0, 1, F3_B, 32'h0000_0103, 32'h0000_00A5, 1, 32'h0);
        do_op(1, 0, F3_HU, 32'h0000_0102, 32'h0, 0, 32'h8001_1234);
        do_op(1, 0, F3_W, 32'h0000_0102, 32'h0, 0, 32'h1111_1111);
        do_op(1, 0, F3_H, 32'h0000_0101, 32'h0, 0, 32'h2222_2222);
        do_op(1, 0, F3_W, 32'h0000_0200, 32'h0, -1, 32'h3333_3333);
        do_op(1, 0, F3_W, 32'h0000_0204, 32'h0, T - 1, 32'hCAFE_F00D);
        do_op(1, 0, 3'b011, 32'h0000_0208, 32'h0, 0, 32'h4444_4444);
        do_op(1, 1, F3_W, 32'h0000_020C, 32'h5555_5555, 0, 32'h6666_6666);
        do_op(0, 1, F3_H, 32'h0000_0302, 32'h1234_ABCD, 0, 32'h0);
        do_op(1, 0, F3_B, 32'h0000_0301, 32'h0, 3, 32'hA1B2_C3D4);

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin rd = 1'b1; wr = 1'b1; end
            else if (r < 10) begin rd = 1'b1; wr = 1'b0; end
            else begin rd = 1'b0; wr = 1'b1; end
            if (rd && !wr) begin
                f3 = ($urandom_range(0, 7) == 0) ? ld_bad[$urandom_range(0, 2)] : ld_ok[$urandom_range(0, 4)];
                r = $urandom_range(0, 9);
                lat = (r < 6) ? r : (r == 6) ? T - 2 : (r == 7) ? T - 1 : (r == 8) ? T : -1;
            end else begin
                f3 = ($urandom_range(0, 7) == 0) ? (3'b100 | 3'($urandom_range(0, 3))) : 3'($urandom_range(0, 2));
                lat = $urandom_range(0, 5);
            end
            do_op(rd, wr, f3, $urandom, $urandom, lat, $urandom);
        end

        // Reset in the middle of an outstanding request.
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        ack_lat = -1;
        lsu_valid = 1'b1; lsu_read = 1'b1; lsu_write = 1'b0;
        funct3 = F3_W; addr = 32'h0000_0300;
        repeat (4) @(negedge clk);
        chk("rst_mid_req_before", {31'b0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mid_bus", {mem_we, mem_wstrb}, 32'd0);
        chk("rst_mid_addr", mem_addr, 32'd0);
        chk("rst_mid_rdm", read_data_mem, 32'd0);
        chk("rst_mid_status", {lsu_done, misaligned, access_err}, 32'd0);
        lsu_valid = 1'b0; lsu_read = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bq.delete();
        rq.delete();
        model_rdm = 32'h0;
        mon_en = 1'b1;
        do_op(0, 1, F3_W, 32'h0000_0104, 32'h1234_5678, 1, 32'h0);
        do_op(1, 0, F3_BU, 32'h0000_0107, 32'h0, 2, 32'h9ABC_DEF0);

        @(posedge clk);
        #1;
        lsu_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("queues_drained", bq.size() + rq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-stage load/store unit of the single-cycle/multi-cycle RV32I core. It sits between execute and the data memory. It issues word-aligned requests over a req/ack bus, with byte strobes and lane-replicated store data. For loads, it right-aligns the addressed byte/halfword into read_data_mem, which feeds the load sign/zero extender downstream. It stalls the pipeline until the access completes and reports misalignment, illegal access and bus timeout.

Parameters:
TIMEOUT_CYCLES, 16, max cycles mem_req stays high without mem_ack before abort (>=1).
CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter (derived, not overridden).

Ports:
clk  input  1  core clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
lsu_valid  input  1  execute presents a memory op; held until lsu_done.
lsu_read  input  1  op is a load.
lsu_write  input  1  op is a store.
funct3  input  3  RV32I load/store funct3.
addr  input  32  byte address.
store_data  input  32  rs2 value.
mem_req  output  1  bus request, held until ack or timeout.
mem_we  output  1  1 = write.
mem_addr  output  32  {addr[31:2],2'b00}.
mem_wdata  output  32  lane-replicated store data.
mem_wstrb  output  4  byte enables (0000 on reads).
mem_rdata  input  32  read word, valid with mem_ack.
mem_ack  input  1  single-cycle completion.
read_data_mem  output  32  right-aligned load data to extender, upper bits zero.
lsu_stall  output  1  freeze upstream pipeline.
lsu_done  output  1  one-cycle completion pulse.
misaligned  output  1  valid with lsu_done.
access_err  output  1  valid with lsu_done; illegal op or timeout.

Behaviour:
- Async reset: state IDLE, counter 0; all outputs 0, read_data_mem 0. mem_req falls immediately on rst_n low, even mid-transaction.
- FSM states: IDLE, WAIT, DONE.
- IDLE, lsu_valid & (lsu_read|lsu_write): classify the op.
  - Illegal: both read and write set; load funct3 in {011,110,111}; store funct3[2]=1. Go to DONE with access_err=1 and no bus access.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0. Go to DONE with misaligned=1 and no bus access.
  - Otherwise: register mem_req=1, mem_we, mem_addr, mem_wdata and mem_wstrb; clear the counter; go to WAIT. mem_req is first high in the cycle after acceptance.
- Store lanes:
  - sb: wdata={4{d[7:0]}}, wstrb=0001<<addr[1:0].
  - sh: wdata={2{d[15:0]}}, wstrb=0011<<addr[1:0].
  - sw: wdata=d, wstrb=1111.
- WAIT: bus outputs held stable.
  - mem_ack=1: drop mem_req, mem_we and mem_wstrb. For loads, latch read_data_mem = mem_rdata >> (8*addr[1:0]) with the width-masked upper bits zero. Go to DONE.
  - No ack: counter increments. When the counter reaches TIMEOUT_CYCLES-1 without ack, drop mem_req, set access_err=1 and read_data_mem=0, and go to DONE.
  - An ack in the same cycle the timeout fires wins; that is not an error.
- DONE: lsu_done=1 for exactly one cycle, flags valid that cycle; next state IDLE. Flags clear when leaving DONE.
- read_data_mem holds until the next completing load; stores do not change it.
- lsu_stall is combinational: lsu_valid & (lsu_read|lsu_write) & (state!=DONE). It falls in the lsu_done cycle so the pipeline advances exactly once per op.
- Latency: an acked access completes with lsu_done at acceptance+2+N cycles, where N is the cycle count from mem_req rising to mem_ack. A misaligned or illegal op gives lsu_done one cycle after acceptance.
- mem_ack outside WAIT is ignored. lsu_valid changes while in WAIT are ignored; the latched op completes.

Decomposition:
- Shared core package: funct3 localparams (F3_B/H/W/BU/HU) and FSM state encodings, also used by the extender and decoder.
- One sub-module, lsu_lane_align: combinational store replication/strobe generation and load right-shift/mask, unit-tested separately.

Test Plan:
1. sw addr=0x100 data=0xDEADBEEF, ack 2 cycles after req -> mem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF; lsu_done pulse; stall low that cycle.
2. sb addr=0x103 data=0x000000A5 -> wdata=0xA5A5A5A5, wstrb=1000; lhu addr=0x102 with mem_rdata=0x8001_1234 -> read_data_mem=0x00008001.
3. lw addr=0x102 -> no mem_req; lsu_done one cycle after acceptance with misaligned=1; lh addr=0x101 -> misaligned=1.
4. Load with no ack, TIMEOUT_CYCLES=16 -> mem_req high exactly 16 cycles, then lsu_done with access_err=1 and read_data_mem=0; repeat with ack on the 16th cycle -> no error.
5. funct3=011 load, and read&write both set -> access_err=1, no bus activity.
6. rst_n low during WAIT -> mem_req drops asynchronously, outputs zero; after release the next sw completes normally.
